bcd_counter: RTL

Parametrised, clocked multi-digit BCD up/down counter for the display and event-count paths. It holds DIGITS packed BCD digits and steps them by one on increment or decrement requests. It also supports synchronous clear and parallel load, and a selectable wrap or saturate mode at the range limits. It reports boundary status and one-cycle wrap/saturate/load-error pulses for downstream cascading and status logic.

---
 rtl/bcd_counter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_counter.sv
// ---------------------------------------------------------------------------
// bcd_counter
//
// Multi-digit packed-BCD up/down counter. It holds DIGITS BCD digits and
// steps them by one per cycle on incr or decr. It also provides a
// synchronous clear and a parallel load, and it can either wrap or
// saturate at the range limits. The status pulses are registered so that
// downstream cascading logic sees clean one-cycle events.
//
// Parameters
//   DIGITS    number of BCD digits (1..8); range 0 .. 10^DIGITS-1
//   SATURATE  0 = wrap at the limits, 1 = hold at the limits
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   clear      in   synchronous clear to zero (highest priority)
//   load       in   synchronous parallel load of load_data
//   load_data  in   packed BCD load value, digit 0 in [3:0]
//   incr       in   count up by one this cycle
//   decr       in   count down by one this cycle
//   data       out  current count, packed BCD
//   at_max     out  count is all nines
//   at_zero    out  count is zero
//   wrap       out  one-cycle pulse: count wrapped at a limit
//   sat        out  one-cycle pulse: step blocked at a limit
//   load_err   out  one-cycle pulse: load_data held a non-BCD digit
// ---------------------------------------------------------------------------
module bcd_counter #(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_data,
    input  logic                incr,
    input  logic                decr,
    output logic [4*DIGITS-1:0] data,
    output logic                at_max,
    output logic                at_zero,
    output logic                wrap,
    output logic                sat,
    output logic                load_err
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};
    localparam logic [W-1:0] ALL_ZERO  = {W{1'b0}};

    // Replace every digit above 9 with 9; valid digits pass through.
    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                r[4*k +: 4] = 4'd9;
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    // True when any digit of v is outside 0..9.
    function automatic logic bcd_has_bad(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    logic [W-1:0] data_q, data_d;
    logic         wrap_q, wrap_d;
    logic         sat_q, sat_d;
    logic         load_err_q, load_err_d;

    logic [W-1:0] inc_val_s;
    logic [W-1:0] dec_val_s;
    logic         inc_carry_s;
    logic         dec_borrow_s;
    logic         at_max_s;
    logic         at_zero_s;
    logic         step_up_s;
    logic         step_dn_s;

    assign at_max_s  = (data_q == ALL_NINES);
    assign at_zero_s = (data_q == ALL_ZERO);
    // Simultaneous incr and decr cancel out.
    assign step_up_s = incr & ~decr;
    assign step_dn_s = decr & ~incr;

    // Increment ripple: a carry turns 9 into 0 and propagates upwards.
    // All nines naturally rolls over to zero.
    always_comb begin
        inc_val_s   = data_q;
        inc_carry_s = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (inc_carry_s && (data_q[4*k +: 4] == 4'd9)) begin
                inc_val_s[4*k +: 4] = 4'd0;
            end else if (inc_carry_s) begin
                inc_val_s[4*k +: 4] = data_q[4*k +: 4] + 4'd1;
                inc_carry_s         = 1'b0;
            end else begin
                inc_val_s[4*k +: 4] = data_q[4*k +: 4];
            end
        end
    end

    // Decrement ripple: a borrow turns 0 into 9 and propagates upwards.
    // Zero naturally rolls under to all nines.
    always_comb begin
        dec_val_s    = data_q;
        dec_borrow_s = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (dec_borrow_s && (data_q[4*k +: 4] == 4'd0)) begin
                dec_val_s[4*k +: 4] = 4'd9;
            end else if (dec_borrow_s) begin
                dec_val_s[4*k +: 4] = data_q[4*k +: 4] - 4'd1;
                dec_borrow_s        = 1'b0;
            end else begin
                dec_val_s[4*k +: 4] = data_q[4*k +: 4];
            end
        end
    end

    // Next-state selection: clear > load > step; pulses default low.
    always_comb begin
        data_d     = data_q;
        wrap_d     = 1'b0;
        sat_d      = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            data_d = ALL_ZERO;
        end else if (load) begin
            data_d     = bcd_clamp(load_data);
            load_err_d = bcd_has_bad(load_data);
        end else if (step_up_s) begin
            if (at_max_s && SATURATE) begin
                sat_d = 1'b1;
            end else if (at_max_s) begin
                data_d = inc_val_s;
                wrap_d = 1'b1;
            end else begin
                data_d = inc_val_s;
            end
        end else if (step_dn_s) begin
            if (at_zero_s && SATURATE) begin
                sat_d = 1'b1;
            end else if (at_zero_s) begin
                data_d = dec_val_s;
                wrap_d = 1'b1;
            end else begin
                data_d = dec_val_s;
            end
        end else begin
            data_d = data_q;
        end
    end

    // State and pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= ALL_ZERO;
            wrap_q     <= 1'b0;
            sat_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            wrap_q     <= wrap_d;
            sat_q      <= sat_d;
            load_err_q <= load_err_d;
        end
    end

    assign data     = data_q;
    assign at_max   = at_max_s;
    assign at_zero  = at_zero_s;
    assign wrap     = wrap_q;
    assign sat      = sat_q;
    assign load_err = load_err_q;

endmodule
